divu_iter: RTL and testbench

- Iterative unsigned 32-bit divider producing quotient and remainder; the division counterpart of the unsigned multiplier in the ALU/multiply-divide unit.
- Restoring radix-2 algorithm, one quotient bit per clock, start/busy/done handshake toward the CPU control path.
- Results stay on the outputs until the next accepted operation, so the HI/LO write-back can sample them at any later time.

---
 rtl/divu_iter.sv | 135 +++++++++++++
 tb/tb_divu_iter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/divu_iter.sv
// divu_iter: iterative unsigned divider, restoring radix-2, one quotient bit per clock.
// q/r/div_zero hold the last completed result until the next accepted operation.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; the only state in which start is accepted
// S_CALC | shifting/subtracting, one quotient bit per edge
// S_FIN  | one cycle with done high; start is ignored here
module divu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   // Dividend shifts out of the MSB while quotient bits fill the freed LSBs.
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   // Partial remainder is always < B after each step, so WIDTH bits hold it;
   // the extra bit only exists in the trial value w_t.
   logic [WIDTH-1:0] r_rem;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_div_zero;

   logic [WIDTH:0]   w_t;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_a_nxt;
   logic             w_last;

   // One restoring step: trial-subtract the divisor from the shifted remainder.
   always_comb begin
      w_t       = {r_rem, r_a[WIDTH-1]};
      w_ge      = (w_t >= {1'b0, r_b});
      // When w_ge holds, t-B < B, so the low WIDTH bits of the difference are exact.
      w_rem_nxt = w_ge ? (w_t[WIDTH-1:0] - r_b) : w_t[WIDTH-1:0];
      w_a_nxt   = {r_a[WIDTH-2:0], w_ge};
      w_last    = (r_state == S_CALC) && (r_cnt == LAST);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; a zero divisor skips straight to the done cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = (divisor == '0) ? S_FIN : S_CALC;
         end
         S_CALC: begin
            if (r_cnt == LAST) w_state_nxt = S_FIN;
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a        <= '0;
         r_b        <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_q        <= '0;
         r_r        <= '0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     r_q        <= '1;
                     r_r        <= dividend;
                     r_div_zero <= 1'b1;
                  end else begin
                     r_a        <= dividend;
                     r_b        <= divisor;
                     r_rem      <= '0;
                     r_cnt      <= '0;
                     r_div_zero <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               r_a   <= w_a_nxt;
               r_rem <= w_rem_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_q        <= w_a_nxt;
                  r_r        <= w_rem_nxt;
                  r_div_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decode registered state only, so no input reaches an output combinationally.
   always_comb begin
      q        = r_q;
      r        = r_r;
      div_zero = r_div_zero;
      busy     = (r_state == S_CALC);
      done     = (r_state == S_FIN);
   end

endmodule

// File: tb/tb_divu_iter.sv
// tb_divu_iter: directed vector table, hand-written handshake/reset sequences,
// and an edge-biased random run checked against the bench's own arithmetic model.
module tb_divu_iter;

   localparam int WIDTH = 32;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
   logic             div_zero;

   int n_pass  = 0;
   int n_total = 0;

   logic [WIDTH-1:0] last_q = '0;
   logic [WIDTH-1:0] last_r = '0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] eq;
      logic [WIDTH-1:0] er;
      logic             edz;
   } vec_t;

   vec_t vecs[14];

   divu_iter #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .q        (q),
      .r        (r),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Called #1 after the accept edge; counts edges until done, busy samples,
   // and any change of q/r before done.
   task automatic wait_done(output int cyc, output int bc, output int chg);
      cyc = 0; bc = 0; chg = 0;
      while (!done && cyc < 100) begin
         if (busy) bc++;
         if (q !== last_q || r !== last_r) chg++;
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic edz, input string tag);
      int cyc, bc, chg, exp_lat;
      exp_lat = (b == 0) ? 0 : WIDTH;
      @(negedge clk);
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = ~a; divisor = ~b;
      wait_done(cyc, bc, chg);
      chk({tag, " latency"}, cyc, exp_lat);
      chk({tag, " busy_cycles"}, bc, exp_lat);
      chk({tag, " qr_stable"}, chg, 0);
      chk({tag, " q"}, q, eq);
      chk({tag, " r"}, r, er);
      chk({tag, " div_zero"}, div_zero, edz);
      chk({tag, " busy_at_done"}, busy, 0);
      last_q = eq; last_r = er;
      @(posedge clk); #1;
      chk({tag, " done_pulse_end"}, done, 0);
   endtask

   function automatic logic [WIDTH-1:0] pick_val();
      int sel;
      int k;
      logic [WIDTH-1:0] one;
      sel = $urandom_range(0, 6);
      k   = $urandom_range(0, WIDTH - 1);
      one = 1;
      case (sel)
         0: return '0;
         1: return one;
         2: return '1;
         3: return one << k;
         4: return (one << k) - one;
         5: return WIDTH'($urandom_range(0, 1000));
         default: return WIDTH'($urandom);
      endcase
   endfunction

   initial begin
      int cyc, bc, chg, dseen;
      logic [WIDTH-1:0] ra, rb, rq, rr;

      vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,   1'b0};
      vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0};
      vecs[2]  = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,   1'b0};
      vecs[3]  = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,1'b1};
      vecs[4]  = '{32'd81,         32'd9,          32'd9,          32'd0,   1'b0};
      vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,   1'b0};
      vecs[6]  = '{32'd7,          32'd7,          32'd1,          32'd0,   1'b0};
      vecs[7]  = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,   1'b0};
      vecs[8]  = '{32'd6,          32'h8000_0000,  32'd0,          32'd6,   1'b0};
      vecs[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0};
      vecs[10] = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,   1'b0};
      vecs[11] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,   1'b1};
      vecs[12] = '{32'd1000,       32'd10,         32'd100,        32'd0,   1'b0};
      vecs[13] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b0};

      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      chk("reset q", q, 0);
      chk("reset r", r, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset div_zero", div_zero, 0);

      for (int i = 0; i < 14; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz, $sformatf("vec%0d", i));

      // start held through busy and FIN: second request lands on the first IDLE edge
      @(negedge clk);
      dividend = 32'd50; divisor = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      dividend = 32'd9; divisor = 32'd9;
      wait_done(cyc, bc, chg);
      chk("b2b first latency", cyc, WIDTH);
      chk("b2b first q", q, 16);
      chk("b2b first r", r, 2);
      last_q = 32'd16; last_r = 32'd2;
      @(posedge clk); #1;
      chk("b2b fin ignored busy", busy, 0);
      chk("b2b fin done low", done, 0);
      @(posedge clk); #1;
      chk("b2b second accepted", busy, 1);
      start = 1'b0;
      wait_done(cyc, bc, chg);
      chk("b2b second latency", cyc, WIDTH);
      chk("b2b second q", q, 1);
      chk("b2b second r", r, 0);
      chk("b2b qr_stable", chg, 0);
      last_q = 32'd1; last_r = 32'd0;
      @(posedge clk); #1;

      // reset in the middle of an operation discards it
      @(negedge clk);
      dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("abort busy before reset", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort q", q, 0);
      chk("abort r", r, 0);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      @(negedge clk); reset = 1'b0;
      last_q = '0; last_r = '0;
      dseen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) dseen++;
      end
      chk("abort no late done", dseen, 0);
      run_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, "after_abort");

      // edge-biased random operands against the bench's arithmetic model
      for (int i = 0; i < 400; i++) begin
         ra = pick_val();
         rb = pick_val();
         rq = (rb == 0) ? '1 : ra / rb;
         rr = (rb == 0) ? ra : ra % rb;
         run_op(ra, rb, rq, rr, (rb == 0), $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
